// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. A word accepted at edge N starts its frame at edge N+1.
// Backpressure: data_ready is low while the FIFO is full. Frames are sent back-to-back while words remain.
module uart_tx_fifo #(
   parameter int FCLK       = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_Tx,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic                          Tx_out,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIVIDER = FCLK / BAUD;
   localparam int CW      = $clog2(DIVIDER);
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int BW      = 4;

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 rdy_q, rdy_d;
   logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]          count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic                 push, pop, tick;
   logic [DATA_BITS-1:0] head;

   assign head = mem_q[rd_q];
   assign push = data_valid && rdy_q;
   assign tick = (cnt_q == CW'(DIVIDER - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         START: begin
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PAR: begin
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (tick) begin
               cnt_d = '0;
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (count_q != '0) pop = 1'b1;
                  else               state_d = IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Loading a frame is shared by the idle start and the back-to-back restart.
      if (pop) begin
         state_d = START;
         shift_d = head;
         par_d   = (PARITY == 1) ? ~(^head) : (^head);
         cnt_d   = '0;
         bit_d   = '0;
      end

      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PAR:     tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);

      wr_d    = push ? wr_q + PW'(1) : wr_q;
      rd_d    = pop  ? rd_q + PW'(1) : rd_q;
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      rdy_d   = (count_d != (PW+1)'(FIFO_DEPTH));
   end

   always_ff @(posedge clk_Tx or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         if (push) mem_q[wr_q] <= data_in;
      end
   end

   assign Tx_out     = tx_q;
   assign busy       = busy_q;
   assign data_ready = rdy_q;
   assign fifo_count = count_q;

endmodule
